// File: rtl/act_broadcast_engine_if.sv
// Regfile read port and network send port of the activation broadcast engine.
// master: engine side (drives rd_en/rd_addr/send_*); slave: regfile + network side.
interface act_broadcast_engine_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ACT_NO_WIDTH = 6,
  parameter int PE_IDX_WIDTH = 6
);
  logic                                rd_en;
  logic [ACT_NO_WIDTH-1:0]             rd_addr;
  logic [DATA_WIDTH-1:0]               rd_data;
  logic                                send_valid;
  logic [ACT_NO_WIDTH+PE_IDX_WIDTH-1:0] send_idx;
  logic [DATA_WIDTH-1:0]               send_data;
  logic                                send_rdy;

  modport master (
    output rd_en, rd_addr,
    output send_valid, send_idx, send_data,
    input  rd_data, send_rdy
  );

  modport slave (
    input  rd_en, rd_addr,
    input  send_valid, send_idx, send_data,
    output rd_data, send_rdy
  );
endinterface

// File: rtl/act_broadcast_engine.sv
// Drains the PE output regfile as (global idx, value) pairs through a 2-entry skid FIFO.
// Ports: clk, rst (sync, active-high), PE_IDX, start, out_act_no, bus (master), busy, done.
// Optional: ACT_ZERO_SKIP_EN drops zero-valued activations instead of sending them.
module act_broadcast_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int ACT_NO_WIDTH = 6,
  parameter int PE_IDX_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PE_IDX_WIDTH-1:0] PE_IDX,
  input  logic                    start,
  input  logic [ACT_NO_WIDTH:0]   out_act_no,
  act_broadcast_engine_if.master  bus,
  output logic                    busy,
  output logic                    done
);
  localparam int IW = ACT_NO_WIDTH + PE_IDX_WIDTH;
  localparam int EW = IW + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ACT_NO_WIDTH:0]   total_q, total_d;
  logic [ACT_NO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ACT_NO_WIDTH-1:0] tag_q, tag_d;
  logic                    inflight_q, inflight_d;
  logic [EW-1:0]           mem_q [2];
  logic [EW-1:0]           mem_d [2];
  logic                    wp_q, wp_d;
  logic                    hp_q, hp_d;
  logic [1:0]              occ_q, occ_d;
  logic                    zero_q, zero_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic pop, push, credit, rd_go, last_rd, flush_exit;

  always_comb begin
    pop = (occ_q != 2'd0) && bus.send_rdy;
`ifdef ACT_ZERO_SKIP_EN
    push = inflight_q && (bus.rd_data != '0);
`else
    push = inflight_q;
`endif
    // occ + inflight - pop < 2, kept non-negative by adding pop on the right
    credit = ({1'b0, occ_q} + {2'b00, inflight_q})
           < ({2'b00, pop} + 3'd2);
    rd_go = (state_q == RUN) && credit;
    last_rd = ({1'b0, rd_ptr_q} + {{ACT_NO_WIDTH{1'b0}}, 1'b1})
            == total_q;
    // exit when the FIFO will be empty after this edge and nothing returns
    flush_exit = !inflight_q &&
                 ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));

    state_d = state_q;
    total_d = total_q;
    rd_ptr_d = rd_ptr_q;
    zero_d = zero_q;
    done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          total_d = out_act_no;
          rd_ptr_d = '0;
          zero_d = (out_act_no == '0);
          state_d = (out_act_no == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_go) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (last_rd) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_exit) begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        // an empty drain never passes FLUSH, so its pulse comes from here
        done_d = zero_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    inflight_d = rd_go;
    tag_d = rd_ptr_q;

    mem_d = mem_q;
    wp_d = wp_q;
    hp_d = hp_q;
    if (push) begin
      mem_d[wp_q] = {tag_q, PE_IDX, bus.rd_data};
      wp_d = ~wp_q;
    end
    if (pop) hp_d = ~hp_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      total_q <= '0;
      rd_ptr_q <= '0;
      tag_q <= '0;
      inflight_q <= 1'b0;
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      hp_q <= 1'b0;
      occ_q <= 2'd0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      rd_ptr_q <= rd_ptr_d;
      tag_q <= tag_d;
      inflight_q <= inflight_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      hp_q <= hp_d;
      occ_q <= occ_d;
      zero_q <= zero_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.rd_en = rd_go;
  assign bus.rd_addr = rd_ptr_q;
  assign bus.send_valid = (occ_q != 2'd0);
  assign bus.send_idx = mem_q[hp_q][EW-1:DATA_WIDTH];
  assign bus.send_data = mem_q[hp_q][DATA_WIDTH-1:0];
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_act_broadcast_engine.sv
// Scoreboard bench for act_broadcast_engine.
// Stimulus pushes expected pairs; a negedge monitor pops and compares.
module tb_act_broadcast_engine;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int PW = 6;
  localparam int IW = AW + PW;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] pe_idx = 6'd5;
  logic [AW:0]   out_act_no = '0;
  logic          busy, done;

  act_broadcast_engine_if #(
    .DATA_WIDTH(DW), .ACT_NO_WIDTH(AW), .PE_IDX_WIDTH(PW)
  ) bus ();

  act_broadcast_engine #(
    .DATA_WIDTH(DW), .ACT_NO_WIDTH(AW), .PE_IDX_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .PE_IDX(pe_idx),
    .start(start), .out_act_no(out_act_no),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf [64];
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? rf[bus.rd_addr] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  int t0 = 0;
  int done_cnt, done_rel, busy_cnt, busy_first;
  int rd_cnt, send_cnt;
  int issued = 0, popped = 0, max_out = 0;
  logic hold_prev = 1'b0;
  logic [IW-1:0] prev_idx;
  logic [DW-1:0] prev_data;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  int rel;
  exp_t e;
  always @(negedge clk) begin
    rel = cyc - t0;
    if (busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = rel;
    end
    if (bus.rd_en) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
    if (hold_prev && bus.send_valid) begin
      chk("hold_idx", bus.send_idx, prev_idx);
      chk("hold_data", bus.send_data, prev_data);
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (bus.send_valid && bus.send_rdy) begin
      send_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_send: got idx %0h, queue empty",
                 bus.send_idx);
      end else begin
        e = q.pop_front();
        chk("send_idx", bus.send_idx, e.idx);
        chk("send_data", bus.send_data, e.data);
        if (e.at >= 0) chk("send_cycle", rel, e.at);
      end
    end
    hold_prev = bus.send_valid && !bus.send_rdy;
    prev_idx = bus.send_idx;
    prev_data = bus.send_data;
    if (rst) begin
      issued = 0;
      popped = 0;
      hold_prev = 1'b0;
    end else begin
      issued += int'(bus.rd_en);
      popped += int'(bus.send_valid && bus.send_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pair(int a, logic [DW-1:0] d, int at);
    exp_t x;
    logic [AW-1:0] a6;
    a6 = a[AW-1:0];
    x.idx = {a6, pe_idx};
    x.data = d;
    x.at = at;
    q.push_back(x);
  endtask

  task automatic kick(int n);
    tick();
    out_act_no = n[AW:0];
    start = 1'b1;
    t0 = cyc;
    done_cnt = 0;
    done_rel = -1;
    busy_cnt = 0;
    busy_first = -1;
    rd_cnt = 0;
    send_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int limit, string name);
    int k;
    k = 0;
    while (done_cnt == 0 && k < limit) begin
      tick();
      k++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, want done in %0d cycles",
               name, limit);
    end
    repeat (4) tick();
    chk({name, "_queue_empty"}, q.size(), 0);
    chk({name, "_done_once"}, done_cnt, 1);
  endtask

  task automatic chk_reset(string name);
    chk({name, "_rd_en"}, bus.rd_en, 0);
    chk({name, "_rd_addr"}, bus.rd_addr, 0);
    chk({name, "_send_valid"}, bus.send_valid, 0);
    chk({name, "_send_idx"}, bus.send_idx, 0);
    chk({name, "_send_data"}, bus.send_data, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  initial begin
    bus.send_rdy = 1'b1;
    for (int i = 0; i < 64; i++) rf[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset("reset");

    // basic drain, exact cycle positions
    rf[0] = 16'h0011; rf[1] = 16'h0022;
    rf[2] = 16'h0033; rf[3] = 16'h0044;
    expect_pair(0, 16'h0011, 3);
    expect_pair(1, 16'h0022, 4);
    expect_pair(2, 16'h0033, 5);
    expect_pair(3, 16'h0044, 6);
    kick(4);
    wait_done(30, "n4");
    chk("n4_done_cycle", done_rel, 7);
    chk("n4_busy_cycles", busy_cnt, 7);
    chk("n4_busy_first", busy_first, 1);
    chk("n4_reads", rd_cnt, 4);
    chk("n4_sends", send_cnt, 4);

    // zero-length drain
    kick(0);
    wait_done(10, "n0");
    chk("n0_done_cycle", done_rel, 2);
    chk("n0_busy_cycles", busy_cnt, 1);
    chk("n0_busy_first", busy_first, 1);
    chk("n0_reads", rd_cnt, 0);
    chk("n0_sends", send_cnt, 0);

    // back-pressure for cycles 3..9
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'hA000 + 16'(i * 17);
      expect_pair(i, rf[i], -1);
    end
    kick(8);
    while (cyc - t0 < 3) tick();
    bus.send_rdy = 1'b0;
    chk("stall_reads_before", rd_cnt, 2);
    repeat (7) tick();
    bus.send_rdy = 1'b1;
    chk("stall_reads_during", rd_cnt, 2);
    #1;
    chk("stall_resume_rd_en", bus.rd_en, 1);
    wait_done(60, "stall");
    chk("stall_sends", send_cnt, 8);

    // full 64-entry drain with random back-pressure
    pe_idx = 6'h2A;
    for (int i = 0; i < 64; i++) begin
      rf[i] = 16'(i * 257) ^ 16'h5A5A;
      expect_pair(i, rf[i], -1);
    end
    max_out = 0;
    kick(64);
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      bus.send_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.send_rdy = 1'b1;
    wait_done(20, "n64");
    chk("n64_sends", send_cnt, 64);
    chk("n64_outstanding_le2", max_out <= 2, 1);

    // reset in cycle 4 of an 8-entry drain
    pe_idx = 6'd5;
    expect_pair(0, rf[0], 3);
    expect_pair(1, rf[1], 4);
    kick(8);
    while (cyc - t0 < 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("abort");
    repeat (12) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_sends", send_cnt, 2);
    chk("abort_queue_empty", q.size(), 0);
    q.delete();
    for (int i = 0; i < 8; i++) expect_pair(i, rf[i], -1);
    kick(8);
    chk("restart_rd_en", bus.rd_en, 1);
    chk("restart_rd_addr", bus.rd_addr, 0);
    wait_done(30, "restart");
    chk("restart_sends", send_cnt, 8);

    // zero-valued activations
    rf[0] = 16'h0000; rf[1] = 16'h0007;
    rf[2] = 16'h0000; rf[3] = 16'h0009;
`ifdef ACT_ZERO_SKIP_EN
    expect_pair(1, 16'h0007, -1);
    expect_pair(3, 16'h0009, -1);
`else
    for (int i = 0; i < 4; i++) expect_pair(i, rf[i], -1);
`endif
    kick(4);
    wait_done(30, "zero");
`ifdef ACT_ZERO_SKIP_EN
    chk("zero_sends", send_cnt, 2);
`else
    chk("zero_sends", send_cnt, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/act_broadcast_engine.md
# act_broadcast_engine

Layer-output drain stage for the processing element. After a layer's computation completes, it scans the PE's output activation register file. It converts each local output address into a global activation index and presents (index, value) pairs to the network interface under a valid/ready handshake. It sits between the ActRegFile output read port and the NetworkInterface send path, and uses a 2-entry skid FIFO to decouple the 1-cycle regfile read latency from router back-pressure.

## Interface
Parameters:
- DATA_WIDTH, 16, activation value width
- ACT_NO_WIDTH, 6, local activation address width (64 activations per PE)
- PE_IDX_WIDTH, 6, PE index width (64 PEs)

Ports:
- clk  input  1  system clock
- rst  input  1  system reset; synchronous, active-high
- PE_IDX  input  PE_IDX_WIDTH  static PE index
- start  input  1  one-cycle pulse that begins a drain; honoured only in IDLE
- out_act_no  input  ACT_NO_WIDTH+1  number of output activations to drain (0..64); sampled on start
- rd_en  output  1  output regfile read enable
- rd_addr  output  ACT_NO_WIDTH  output regfile read address
- rd_data  input  DATA_WIDTH  read data; valid exactly one cycle after rd_en
- send_valid  output  1  send pair valid
- send_idx  output  ACT_NO_WIDTH+PE_IDX_WIDTH  global index = {local_addr, PE_IDX}
- send_data  output  DATA_WIDTH  activation value
- send_rdy  input  1  network interface accepts the pair when send_valid && send_rdy
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the drain completes

## Operation
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE: on start, latch out_act_no into total and clear rd_ptr. Go to DONE if total==0, otherwise go to RUN. A start pulse outside IDLE is ignored.
  - RUN: issue a read at rd_ptr when credit allows, then increment rd_ptr. When the read with rd_ptr==total-1 is issued, go to FLUSH.
  - FLUSH: wait until there is no read in flight and the FIFO is empty, then go to DONE.
  - DONE: assert done for exactly one cycle, then go to IDLE.
- Read credit: issue a read iff occ + inflight - pop < 2.
  - occ is FIFO occupancy (0..2).
  - inflight is a read issued in the previous cycle.
  - pop = send_valid && send_rdy.
  - The FIFO therefore never overflows.
- Each returning read is tagged with its local address (delayed rd_addr) and written to the FIFO tail as {idx={addr,PE_IDX}, data}.
- send_valid = FIFO non-empty. send_idx and send_data come from the FIFO head and hold stable while send_valid && !send_rdy.
- A simultaneous push and pop is legal at any occupancy below 2, and occupancy is unchanged.
- Pairs are sent in strictly ascending local address order.
- The FIFO uses wrap-around read/write pointers (1 bit each) plus an occupancy counter.

## Timing
- Reset values: rd_en=0, rd_addr=0, send_valid=0, send_idx=0, send_data=0, busy=0, done=0. State goes to IDLE and the FIFO and in-flight flag are cleared.
- Reset asserted mid-drain aborts the drain at the next edge. No done pulse is produced.
- Latency with start in cycle 0:
  - rd_en in cycle 1 (addr 0), rd_data in cycle 2.
  - First send_valid in cycle 3.
- Throughput is one pair per cycle while send_rdy stays high.
- Drain of N activations with send_rdy held high:
  - Last send_valid in cycle N+2.
  - done in cycle N+3.
  - busy high in cycles 1..N+3.
- out_act_no==0: done in cycle 2, with no rd_en and no send_valid.
- send_rdy low: at most 2 pairs are buffered and reads stall. Reads resume in the cycle that pop occurs.

## Configuration
- ACT_ZERO_SKIP_EN defined:
  - A returning value equal to 0 is not pushed into the FIFO; its read still consumes a credit slot.
  - Zero activations are never sent.
  - done timing becomes data-dependent, but done still fires exactly one cycle after the FLUSH exit condition.
- ACT_ZERO_SKIP_EN undefined: every one of the N activations is sent, zeros included.

## Test plan
- PE_IDX=5, out_act_no=4, regfile values {0x0011,0x0022,0x0033,0x0044}, send_rdy=1 -> send_idx 0x005,0x045,0x085,0x0C5 with those values in cycles 3..6; done in cycle 7.
- out_act_no=0 start -> no rd_en, no send_valid; done in cycle 2; busy high only in cycle 1.
- out_act_no=8, send_rdy low for cycles 3..9 -> at most 2 reads complete before the stall; the head pair stays stable; all 8 pairs are delivered in order with no loss or duplication; done fires once.
- out_act_no=64, send_rdy toggling pseudo-randomly -> 64 pairs with indices {0..63,PE_IDX} in ascending order; the FIFO never exceeds 2 entries.
- rst asserted in cycle 4 of an 8-activation drain -> next cycle all outputs are at reset values and there is no done pulse; a fresh start then drains correctly from address 0.
- ACT_ZERO_SKIP_EN, values {0,7,0,9} -> only (addr1,7) and (addr3,9) are sent; done fires after both are accepted.
